// File: rtl/pipe_scoreboard.sv
// Register-write scoreboard for a DEPTH-stage post-decode pipeline: decides
// decode load-use stalls and registers the per-operand forwarding select for E.
module pipe_scoreboard #(
  parameter int REG_BITS   = 5,
  parameter int DEPTH      = 3,
  parameter int NSRC       = 2,
  parameter int ALU_READY  = 1,
  parameter int LOAD_READY = 2,
  parameter int SELW       = $clog2(DEPTH)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         advance,
  input  logic                         issue_valid,
  input  logic                         issue_writes,
  input  logic                         issue_load,
  input  logic [REG_BITS-1:0]          issue_rd,
  input  logic [NSRC*REG_BITS-1:0]     issue_src,
  input  logic [NSRC-1:0]              issue_src_used,
  input  logic                         flush_d,
  input  logic [DEPTH-1:0]             flush_mask,
  output logic                         stall_d,
  output logic [NSRC*SELW-1:0]         fwd_sel_e,
  output logic [$clog2(DEPTH+1)-1:0]   inflight
);
  localparam int CNTW = $clog2(DEPTH+1);

  logic [DEPTH-1:0]    entValid;
  logic [DEPTH-1:0]    nextValid;
  logic [DEPTH-1:0]    entLoad;
  logic [REG_BITS-1:0] entRd [DEPTH];
  logic [NSRC-1:0]     matchFound;
  logic [NSRC-1:0]     opStall;
  logic [SELW-1:0]     matchStage [NSRC];
  logic                accept;
  logic [NSRC*SELW-1:0] nextFwd;
  logic [CNTW-1:0]     nextCount;

  function automatic int readyStage(input logic isLoad);
    return isLoad ? LOAD_READY : ALU_READY;
  endfunction

  // Scan oldest to youngest so the youngest live producer is the one kept.
  always_comb begin
    for (int i = 0; i < NSRC; i++) begin
      matchFound[i] = 1'b0;
      matchStage[i] = '0;
      for (int s = DEPTH-1; s >= 0; s--) begin
        if (issue_src_used[i] && (issue_src[i*REG_BITS +: REG_BITS] != '0) &&
            entValid[s] && !flush_mask[s] &&
            (entRd[s] == issue_src[i*REG_BITS +: REG_BITS])) begin
          matchFound[i] = 1'b1;
          matchStage[i] = SELW'(s);
        end
      end
    end
  end

  // A producer in the last stage is retiring through the write-through regfile.
  always_comb begin
    opStall = '0;
    nextFwd = '0;
    for (int i = 0; i < NSRC; i++) begin
      if (matchFound[i] && (int'(matchStage[i]) < DEPTH-1)) begin
        if (int'(matchStage[i]) + 1 < readyStage(entLoad[matchStage[i]]))
          opStall[i] = 1'b1;
        nextFwd[i*SELW +: SELW] = SELW'(int'(matchStage[i]) + 1);
      end
    end
    stall_d = issue_valid & ~flush_d & (|opStall);
    accept  = issue_valid & ~flush_d & ~stall_d;
    if (!accept)
      nextFwd = '0;
  end

  always_comb begin
    nextValid    = '0;
    nextValid[0] = accept & issue_writes & (issue_rd != '0);
    for (int s = 1; s < DEPTH; s++)
      nextValid[s] = entValid[s-1] & ~flush_mask[s-1];
    nextCount = '0;
    for (int s = 0; s < DEPTH; s++)
      nextCount = nextCount + CNTW'(nextValid[s]);
  end

  // Stage boundary: control state (valid bits, selects, count) is reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      entValid  <= '0;
      fwd_sel_e <= '0;
      inflight  <= '0;
    end else if (advance) begin
      entValid  <= nextValid;
      fwd_sel_e <= nextFwd;
      inflight  <= nextCount;
    end
  end

  // Stage boundary: entry payload only matters when its valid bit is set.
  always_ff @(posedge clk) begin
    if (advance) begin
      entRd[0]   <= issue_rd;
      entLoad[0] <= issue_load;
      for (int s = 1; s < DEPTH; s++) begin
        entRd[s]   <= entRd[s-1];
        entLoad[s] <= entLoad[s-1];
      end
    end
  end
endmodule

// File: tb/tb_pipe_scoreboard.sv
// Bench for pipe_scoreboard: queue-based producer model checked every cycle on
// the default instance, plus directed literal checks on both instances.
module tb_pipe_scoreboard;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rstA, advA, validA, writesA, loadA, flushDA, stallA;
  logic [4:0] rdA;
  logic [9:0] srcA;
  logic [1:0] usedA;
  logic [2:0] maskA;
  logic [3:0] fwdA;
  logic [1:0] inflA;

  logic       rstB, advB, validB, writesB, loadB, flushDB, stallB;
  logic [4:0] rdB;
  logic [9:0] srcB;
  logic [1:0] usedB;
  logic [4:0] maskB;
  logic [5:0] fwdB;
  logic [2:0] inflB;

  pipe_scoreboard dutA (
    .clk(clk), .reset(rstA), .advance(advA), .issue_valid(validA),
    .issue_writes(writesA), .issue_load(loadA), .issue_rd(rdA),
    .issue_src(srcA), .issue_src_used(usedA), .flush_d(flushDA),
    .flush_mask(maskA), .stall_d(stallA), .fwd_sel_e(fwdA), .inflight(inflA)
  );

  pipe_scoreboard #(.DEPTH(5), .ALU_READY(1), .LOAD_READY(3)) dutB (
    .clk(clk), .reset(rstB), .advance(advB), .issue_valid(validB),
    .issue_writes(writesB), .issue_load(loadB), .issue_rd(rdB),
    .issue_src(srcB), .issue_src_used(usedB), .flush_d(flushDB),
    .flush_mask(maskB), .stall_d(stallB), .fwd_sel_e(fwdB), .inflight(inflB)
  );

  int nChecks = 0;
  int nFails  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model of instance A: in-flight register writers with their current stage.
  typedef struct { logic [4:0] rd; bit load; int stage; } prod_t;
  prod_t      q[$];
  logic [3:0] mSel;
  bit         checkOn = 1'b0;

  function automatic void decideA(output bit stall, output logic [3:0] sel);
    bit acc;
    stall = 1'b0;
    sel   = '0;
    for (int i = 0; i < 2; i++) begin
      logic [4:0] src;
      int best;
      int st;
      int readyAt;
      src  = srcA[i*5 +: 5];
      best = -1;
      if (usedA[i] && src != 5'd0)
        for (int k = 0; k < q.size(); k++)
          if (q[k].rd == src && !maskA[q[k].stage] &&
              (best < 0 || q[k].stage < q[best].stage))
            best = k;
      if (best >= 0 && q[best].stage < 2) begin
        st      = q[best].stage;
        readyAt = q[best].load ? 2 : 1;
        // the consumer reaches E when the producer reaches st+1
        if (st + 1 < readyAt) stall = 1'b1;
        else sel[i*2 +: 2] = 2'(st + 1);
      end
    end
    if (!validA || flushDA) stall = 1'b0;
    acc = validA && !flushDA && !stall;
    if (!acc) sel = '0;
  endfunction

  always @(posedge clk) begin
    bit         st;
    logic [3:0] sl;
    prod_t      nq[$];
    prod_t      p;
    if (rstA) begin
      q.delete();
      mSel    = '0;
      checkOn = 1'b1;
    end else if (advA) begin
      decideA(st, sl);
      nq.delete();
      foreach (q[k])
        if (!maskA[q[k].stage] && q[k].stage < 2) begin
          p = q[k];
          p.stage = p.stage + 1;
          nq.push_back(p);
        end
      if (validA && !flushDA && !st && writesA && rdA != 5'd0) begin
        p.rd = rdA; p.load = loadA; p.stage = 0;
        nq.push_front(p);
      end
      q    = nq;
      mSel = sl;
    end
  end

  always @(negedge clk) begin
    bit         st;
    logic [3:0] sl;
    if (checkOn) begin
      decideA(st, sl);
      check("modelStall", stallA, st);
      check("modelFwd", fwdA, mSel);
      check("modelInflight", inflA, q.size());
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issueA(input bit ld, input logic [4:0] rd, input logic [4:0] s0,
                        input logic [4:0] s1, input logic [1:0] used);
    validA = 1'b1; writesA = 1'b1; loadA = ld; rdA = rd;
    srcA = {s1, s0}; usedA = used; flushDA = 1'b0;
    #1;
  endtask

  task automatic idleA();
    validA = 1'b0; writesA = 1'b0; loadA = 1'b0; rdA = '0;
    srcA = '0; usedA = '0; flushDA = 1'b0;
    #1;
  endtask

  task automatic issueB(input bit ld, input logic [4:0] rd, input logic [4:0] s0,
                        input logic [4:0] s1, input logic [1:0] used);
    validB = 1'b1; writesB = 1'b1; loadB = ld; rdB = rd;
    srcB = {s1, s0}; usedB = used; flushDB = 1'b0;
    #1;
  endtask

  task automatic idleB();
    validB = 1'b0; writesB = 1'b0; loadB = 1'b0; rdB = '0;
    srcB = '0; usedB = '0; flushDB = 1'b0;
    #1;
  endtask

  initial begin
    rstA = 1'b1; advA = 1'b1; maskA = '0;
    rstB = 1'b1; advB = 1'b1; maskB = '0;
    idleA();
    idleB();
    repeat (2) @(posedge clk);
    #1;
    rstA = 1'b0; rstB = 1'b0;
    #1;
    check("rstStall", stallA, 0);
    check("rstFwd", fwdA, 0);
    check("rstInflight", inflA, 0);

    // add x5, x1, x2 into an empty pipe
    issueA(0, 5, 1, 2, 2'b11);
    check("addStall", stallA, 0);
    tick(); idleA();
    check("addFwd", fwdA, 0);
    check("addInflight", inflA, 1);
    repeat (3) tick();

    // back-to-back ALU dependency forwards from M
    issueA(0, 3, 0, 0, 2'b00); tick();
    issueA(0, 4, 3, 1, 2'b11);
    check("aluStall", stallA, 0);
    tick(); idleA();
    check("aluFwdM", fwdA, 4'b0001);
    repeat (3) tick();

    // one unrelated instruction between: forward from W
    issueA(0, 3, 0, 0, 2'b00); tick();
    issueA(0, 9, 1, 2, 2'b11); tick();
    issueA(0, 4, 3, 0, 2'b01); tick(); idleA();
    check("aluFwdW", fwdA, 4'b0010);
    repeat (3) tick();

    // both operands name the same producer
    issueA(0, 3, 0, 0, 2'b00); tick();
    issueA(0, 4, 3, 3, 2'b11); tick(); idleA();
    check("twinFwd", fwdA, 4'b0101);
    repeat (3) tick();

    // load-use: one stall cycle, then forward from W
    issueA(1, 6, 0, 0, 2'b00); tick();
    issueA(0, 7, 6, 1, 2'b11);
    check("luStall", stallA, 1);
    tick();
    check("luBubbleFwd", fwdA, 0);
    check("luRetryStall", stallA, 0);
    tick(); idleA();
    check("luFwd", fwdA, 4'b0010);
    check("luInflight", inflA, 2);
    repeat (3) tick();

    // producer squashed in the same cycle as the consumer
    issueA(1, 6, 0, 0, 2'b00); tick();
    issueA(0, 7, 6, 0, 2'b01);
    maskA = 3'b001; #1;
    check("flushStall", stallA, 0);
    tick(); idleA(); maskA = '0; #1;
    check("flushFwd", fwdA, 0);
    check("flushInflight", inflA, 1);
    repeat (3) tick();

    // hold for three cycles in the middle of a load-use stall
    issueA(1, 6, 0, 0, 2'b00); tick();
    issueA(0, 7, 6, 0, 2'b01);
    check("preHoldStall", stallA, 1);
    advA = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      check("holdStall", stallA, 1);
      check("holdFwd", fwdA, 0);
      check("holdInflight", inflA, 1);
    end
    advA = 1'b1; #1;
    tick();
    check("resumeBubbleFwd", fwdA, 0);
    check("resumeStall", stallA, 0);
    tick(); idleA();
    check("resumeFwd", fwdA, 4'b0010);
    repeat (3) tick();

    // x0 as destination and as source never interacts
    issueA(1, 0, 0, 0, 2'b00); tick();
    issueA(0, 8, 0, 0, 2'b11);
    check("x0Stall", stallA, 0);
    tick(); idleA();
    check("x0Fwd", fwdA, 0);
    check("x0Inflight", inflA, 1);
    repeat (3) tick();

    // decode squash suppresses the stall and inserts nothing
    issueA(1, 6, 0, 0, 2'b00); tick();
    issueA(0, 7, 6, 0, 2'b01);
    flushDA = 1'b1; #1;
    check("flushDStall", stallA, 0);
    tick(); idleA();
    check("flushDFwd", fwdA, 0);
    check("flushDInflight", inflA, 1);
    repeat (3) tick();

    // deeper pipe: load ready at stage 3 gives a two-cycle stall
    issueB(1, 7, 0, 0, 2'b00); tick();
    issueB(0, 8, 7, 0, 2'b01);
    check("bStall1", stallB, 1);
    tick();
    check("bStall2", stallB, 1);
    check("bBubbleFwd", fwdB, 0);
    tick();
    check("bStallEnd", stallB, 0);
    tick(); idleB();
    check("bFwd", fwdB, 3);
    check("bInflight", inflB, 2);
    repeat (5) tick();

    // reset in the middle of a stall clears everything
    issueB(1, 7, 0, 0, 2'b00); tick();
    issueB(0, 8, 7, 0, 2'b01);
    check("bPreRstStall", stallB, 1);
    rstB = 1'b1;
    tick();
    rstB = 1'b0; #1;
    check("bRstStall", stallB, 0);
    check("bRstInflight", inflB, 0);
    check("bRstFwd", fwdB, 0);
    idleB();
    repeat (2) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end
endmodule

// File: doc/pipe_scoreboard.md
Name: pipe_scoreboard

Overview:
- Parametrised successor to the fixed E/M/W hazard logic of the 5-stage RISC-V pipeline.
- Tracks in-flight register writes across DEPTH post-decode stages, one shift-register entry per stage. Stage 0 = E and stage DEPTH-1 = W.
- Decides decode-stage load-use stalls for NSRC source operands with a per-instruction result-ready stage.
- Registers the forwarding select each operand uses in E on the next cycle. Supports a global pipeline hold and per-stage squash for branch redirect.

Parameters:
- REG_BITS, 5, register index width.
- DEPTH, 3, number of tracked stages after decode (E, M, W); legal range 2..8.
- NSRC, 2, source operands per instruction.
- ALU_READY, 1, first stage whose forward path carries a non-load result.
- LOAD_READY, 2, first stage whose forward path carries load data; must satisfy ALU_READY <= LOAD_READY <= DEPTH-1.
- SELW, $clog2(DEPTH), width of one forwarding select.

Ports:
- clk  in  1  clock, all state updates on posedge.
- reset  in  1  synchronous, active-high; clears all state.
- advance  in  1  pipeline moves this cycle; low = hold everything (pause).
- issue_valid  in  1  decode holds a real instruction.
- issue_writes  in  1  decode instruction writes rd.
- issue_load  in  1  decode instruction is a load (ready at LOAD_READY, else ALU_READY).
- issue_rd  in  REG_BITS  destination of decode instruction.
- issue_src  in  NSRC*REG_BITS  source indices; operand i in bits [i*REG_BITS +: REG_BITS].
- issue_src_used  in  NSRC  operand i is actually read.
- flush_d  in  1  squash decode instruction; nothing is inserted.
- flush_mask  in  DEPTH  bit s squashes the stage-s entry at this edge.
- stall_d  out  1  hold F/D; a bubble enters stage 0 instead.
- fwd_sel_e  out  NSRC*SELW  per-operand select for the instruction now in E: 0 = regfile, k = value from stage k (1..DEPTH-1).
- inflight  out  $clog2(DEPTH+1)  count of valid entries.

Behaviour:
- Entry s holds {v, rd, rdy}; rdy = LOAD_READY if issue_load else ALU_READY. v is set only if issue_writes and issue_rd != 0, so x0 never matches.
- Match for operand i: issue_src_used[i], src != 0, and the youngest (lowest s) entry with v, rd == src and flush_mask[s]=0. Older matches are ignored once a younger one is found.
- stall_d is combinational:
  - stall_d = issue_valid & !flush_d & any operand matching at s with s+1 < rdy[s] and s+1 <= DEPTH-1.
  - A match at s = DEPTH-1 is retiring; the regfile is write-through, so it causes no stall and no forward.
- accept = issue_valid & !flush_d & !stall_d.
- Posedge with reset: all v=0, fwd_sel_e=0. reset overrides advance and flushes.
- Posedge with advance=0 and no reset: no state change. Flush inputs are ignored, and the redirect source must hold them until advance.
- Posedge with advance=1 and no reset:
  - for s = DEPTH-1 down to 1, entry[s] <= entry[s-1] with v cleared if flush_mask[s-1]. The entry at DEPTH-1 is dropped.
  - entry[0] <= accept ? new entry : bubble (v=0). flush_mask[0] applies to the old stage-0 entry, which is handled by the shift.
  - fwd_sel_e[i] <= accept & matched at s with s+1 <= DEPTH-1 ? s+1 : 0.
  - Under stall or flush, fwd_sel_e is all 0 (bubble in E).
- inflight is a registered popcount of v, updated at the same edge; its range is 0..DEPTH.
- Simultaneous events:
  - A flushed producer never causes a stall or a forward in the same cycle.
  - A producer in its ready stage gives fwd = its stage number and no stall.
  - Two operands naming the same register get identical selects.
- Latency: the stall is visible in the same cycle. fwd_sel_e is valid the cycle after the consumer is accepted and stays stable while advance=0.

Test Plan:
- Reset then idle, issue add x5 (srcs x1,x2) -> stall_d=0, next cycle fwd_sel_e=0/0, inflight=1.
- add x3 then add x4 using x3 (default params) -> no stall; E-operand select for x3 = 1 (M). One unrelated instruction between them -> select = 2 (W).
- lw x6 then add using x6 -> stall_d=1 for one cycle, bubble inserted (fwd 0/0); on the retry the select = 2, and inflight stays at most 3.
- lw x6 in stage 0, flush_mask=3'b001 on the same cycle as an add reading x6 -> stall_d=0 and the select = 0.
- advance=0 for 3 cycles mid-stall -> all outputs frozen; then advance=1 resumes with identical values. Writes to x0 and src x0 never stall or forward.
- DEPTH=5, LOAD_READY=3, ALU_READY=1: lw x7 followed immediately by a user -> stall for exactly 2 cycles, then the select = 3. Reset asserted mid-stall -> next cycle stall_d=0 and inflight=0.
